// File: rtl/hazard_control.sv
// Pipeline hazard and stall controller feeding the ID-stage decoder.
// It detects load-use hazards and taken-branch flushes, and freezes the pipeline
// while data memory is busy. A watchdog halts the core if memory never answers,
// and saturating counters record stall and flush cycles.
module hazard_control #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [4:0]  IFID_RS1_i,
   input  logic [4:0]  IFID_RS2_i,
   input  logic [6:0]  IFID_Op_i,
   input  logic        IDEX_MemRead_i,
   input  logic [4:0]  IDEX_RD_i,
   input  logic        Branch_taken_i,
   input  logic        MemReq_i,
   input  logic        MemReady_i,
   output logic        NoOp_o,
   output logic        PCWrite_o,
   output logic        IFIDWrite_o,
   output logic        IFIDFlush_o,
   output logic        PipeStall_o,
   output logic        MemTimeout_o,
   output logic [31:0] StallCount_o,
   output logic [31:0] FlushCount_o
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      HALT     = 2'd2
   } state_t;

   localparam logic [7:0]  WAIT_LAST = 8'(MEM_TIMEOUT - 1);
   localparam logic [31:0] CNT_MAX   = 32'hFFFF_FFFF;

   state_t      state_q, state_d;
   logic [7:0]  wait_cnt_q, wait_cnt_d;
   logic        timeout_q, timeout_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;

   logic rs1_used, rs2_used, load_use, mem_busy;

   // Decode which source registers the ID instruction actually reads
   always_comb begin
      rs1_used = 1'b0;
      rs2_used = 1'b0;
      case (IFID_Op_i)
         7'b0110011, 7'b0100011, 7'b1100011: begin
            rs1_used = 1'b1;
            rs2_used = 1'b1;
         end
         7'b0010011, 7'b0000011: rs1_used = 1'b1;
         default: ;
      endcase
   end

   assign load_use = IDEX_MemRead_i && (IDEX_RD_i != 5'd0) &&
                     ((rs1_used && (IFID_RS1_i == IDEX_RD_i)) ||
                      (rs2_used && (IFID_RS2_i == IDEX_RD_i)));
   assign mem_busy = MemReq_i && !MemReady_i;

   // Prioritised pipeline control; reset forces a bubble with the PC frozen
   always_comb begin
      NoOp_o      = 1'b0;
      PCWrite_o   = 1'b1;
      IFIDWrite_o = 1'b1;
      IFIDFlush_o = 1'b0;
      PipeStall_o = 1'b0;
      if (rst_i) begin
         NoOp_o      = 1'b1;
         PCWrite_o   = 1'b0;
         IFIDWrite_o = 1'b0;
      end else if (state_q == HALT) begin
         NoOp_o      = 1'b1;
         PCWrite_o   = 1'b0;
         IFIDWrite_o = 1'b0;
         PipeStall_o = 1'b1;
      end else if (mem_busy) begin
         // Branch stays in ID and is re-evaluated once memory releases
         PCWrite_o   = 1'b0;
         IFIDWrite_o = 1'b0;
         PipeStall_o = 1'b1;
      end else if (load_use) begin
         // Load-use wins over a branch: the branch operands are not valid yet
         NoOp_o      = 1'b1;
         PCWrite_o   = 1'b0;
         IFIDWrite_o = 1'b0;
      end else if (Branch_taken_i) begin
         IFIDFlush_o = 1'b1;
      end
   end

   // Memory-wait FSM with watchdog, plus saturating stall/flush counters
   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      timeout_d   = timeout_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      case (state_q)
         RUN: begin
            if (mem_busy) begin
               state_d    = MEM_WAIT;
               wait_cnt_d = 8'd0;
            end
         end
         MEM_WAIT: begin
            if (mem_busy) begin
               wait_cnt_d = wait_cnt_q + 8'd1;
               if (wait_cnt_q == WAIT_LAST) begin
                  state_d   = HALT;
                  timeout_d = 1'b1;
               end
            end else if (MemReq_i && MemReady_i) begin
               state_d = RUN;
            end
         end
         HALT:    state_d = HALT;
         default: state_d = RUN;
      endcase
      if ((state_q != HALT) && !PCWrite_o && (stall_cnt_q != CNT_MAX))
         stall_cnt_d = stall_cnt_q + 32'd1;
      if (IFIDFlush_o && (flush_cnt_q != CNT_MAX))
         flush_cnt_d = flush_cnt_q + 32'd1;
   end

   // State, watchdog and counter registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= RUN;
         wait_cnt_q  <= 8'd0;
         timeout_q   <= 1'b0;
         stall_cnt_q <= 32'd0;
         flush_cnt_q <= 32'd0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         timeout_q   <= timeout_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign MemTimeout_o = timeout_q;
   assign StallCount_o = stall_cnt_q;
   assign FlushCount_o = flush_cnt_q;

endmodule

// File: tb/tb_hazard_control.sv
// Directed bench for hazard_control with MEM_TIMEOUT=4.
module tb_hazard_control;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  rs1, rs2, rd;
   logic [6:0]  op;
   logic        mem_read, br, req, rdy;
   logic        noop, pcw, ifidw, flush, pstall, tmo;
   logic [31:0] scnt, fcnt;

   int vecs = 0;
   int errs = 0;
   logic [31:0] base_s, base_f;

   always #5 clk = ~clk;

   hazard_control #(.MEM_TIMEOUT(4)) dut (
      .clk_i(clk), .rst_i(rst),
      .IFID_RS1_i(rs1), .IFID_RS2_i(rs2), .IFID_Op_i(op),
      .IDEX_MemRead_i(mem_read), .IDEX_RD_i(rd),
      .Branch_taken_i(br), .MemReq_i(req), .MemReady_i(rdy),
      .NoOp_o(noop), .PCWrite_o(pcw), .IFIDWrite_o(ifidw),
      .IFIDFlush_o(flush), .PipeStall_o(pstall), .MemTimeout_o(tmo),
      .StallCount_o(scnt), .FlushCount_o(fcnt)
   );

   // Advance one clock; inputs are changed 1ns after the edge and checked 2ns later
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rst = 1'b0; rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0; op = 7'd0;
      mem_read = 1'b0; br = 1'b0; req = 1'b0; rdy = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      #2;
      vecs++;
      if ({noop, pcw, ifidw, flush, pstall} !== 5'b10000) begin
         errs++; $display("FAIL reset_outputs got %b want 10000", {noop, pcw, ifidw, flush, pstall});
      end
      tick();
      tick();
      vecs++;
      if (scnt !== 32'd0 || fcnt !== 32'd0 || tmo !== 1'b0) begin
         errs++; $display("FAIL reset_regs got s=%0d f=%0d t=%b want 0 0 0", scnt, fcnt, tmo);
      end
      rst = 1'b0;
      #2;
      vecs++;
      if ({noop, pcw, ifidw, flush, pstall} !== 5'b01100) begin
         errs++; $display("FAIL idle_outputs got %b want 01100", {noop, pcw, ifidw, flush, pstall});
      end
      tick();
   endtask

   task automatic test_load_use();
      base_s = scnt;
      mem_read = 1'b1; rd = 5'd5; rs2 = 5'd5; rs1 = 5'd0; op = 7'b0110011;
      #2;
      vecs++;
      if ({noop, pcw, ifidw, pstall, flush} !== 5'b10000) begin
         errs++; $display("FAIL load_use_stall got %b want 10000", {noop, pcw, ifidw, pstall, flush});
      end
      tick();
      mem_read = 1'b0;
      #2;
      vecs++;
      if (noop !== 1'b0 || pcw !== 1'b1 || scnt !== base_s + 32'd1) begin
         errs++; $display("FAIL load_use_release got noop=%b pcw=%b scnt=%0d want 0 1 %0d", noop, pcw, scnt, base_s + 32'd1);
      end
      mem_read = 1'b1; op = 7'b0010011;
      #2;
      vecs++;
      if (noop !== 1'b0 || pcw !== 1'b1) begin
         errs++; $display("FAIL itype_rs2_unused got noop=%b pcw=%b want 0 1", noop, pcw);
      end
      op = 7'b0110011; rd = 5'd0; rs2 = 5'd0;
      #2;
      vecs++;
      if (noop !== 1'b0 || pcw !== 1'b1) begin
         errs++; $display("FAIL rd_zero got noop=%b pcw=%b want 0 1", noop, pcw);
      end
      tick();
      idle_inputs();
   endtask

   task automatic test_branch();
      base_f = fcnt;
      br = 1'b1;
      #2;
      vecs++;
      if ({flush, pcw, ifidw, noop} !== 4'b1110) begin
         errs++; $display("FAIL branch_flush got %b want 1110", {flush, pcw, ifidw, noop});
      end
      tick();
      vecs++;
      if (fcnt !== base_f + 32'd1) begin
         errs++; $display("FAIL flush_count got %0d want %0d", fcnt, base_f + 32'd1);
      end
      op = 7'b1100011; rs1 = 5'd7; rd = 5'd7; mem_read = 1'b1;
      #2;
      vecs++;
      if ({noop, pcw, flush} !== 3'b100) begin
         errs++; $display("FAIL branch_load_use got %b want 100", {noop, pcw, flush});
      end
      tick();
      mem_read = 1'b0;
      #2;
      vecs++;
      if ({noop, pcw, flush} !== 3'b011) begin
         errs++; $display("FAIL branch_after_stall got %b want 011", {noop, pcw, flush});
      end
      tick();
      vecs++;
      if (fcnt !== base_f + 32'd2) begin
         errs++; $display("FAIL flush_count2 got %0d want %0d", fcnt, base_f + 32'd2);
      end
      idle_inputs();
   endtask

   task automatic test_mem_wait();
      do_reset();
      req = 1'b1; rdy = 1'b0; br = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #2;
         vecs++;
         if ({pstall, pcw, ifidw, noop, flush} !== 5'b10000) begin
            errs++; $display("FAIL mem_busy_%0d got %b want 10000", i, {pstall, pcw, ifidw, noop, flush});
         end
         tick();
      end
      br = 1'b0; rdy = 1'b1;
      #2;
      vecs++;
      if (pstall !== 1'b0 || pcw !== 1'b1) begin
         errs++; $display("FAIL mem_ready got pstall=%b pcw=%b want 0 1", pstall, pcw);
      end
      tick();
      req = 1'b0;
      vecs++;
      if (scnt !== 32'd3 || dut.state_q !== 2'd0 || fcnt !== 32'd0) begin
         errs++; $display("FAIL mem_wait_end got scnt=%0d state=%0d fcnt=%0d want 3 0 0", scnt, dut.state_q, fcnt);
      end
      #2;
      vecs++;
      if (pstall !== 1'b0 || pcw !== 1'b1) begin
         errs++; $display("FAIL ready_no_req got pstall=%b pcw=%b want 0 1", pstall, pcw);
      end
      tick();
      idle_inputs();
   endtask

   task automatic test_watchdog();
      do_reset();
      req = 1'b1; rdy = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      vecs++;
      if (tmo !== 1'b1 || {noop, pcw, ifidw, pstall, flush} !== 5'b10010) begin
         errs++; $display("FAIL halt_entry got tmo=%b ctl=%b want 1 10010", tmo, {noop, pcw, ifidw, pstall, flush});
      end
      base_s = scnt;
      rdy = 1'b1;
      tick();
      tick();
      vecs++;
      if (tmo !== 1'b1 || pstall !== 1'b1 || pcw !== 1'b0 || scnt !== base_s) begin
         errs++; $display("FAIL halt_sticky got tmo=%b pstall=%b pcw=%b scnt=%0d want 1 1 0 %0d", tmo, pstall, pcw, scnt, base_s);
      end
      req = 1'b0; rdy = 1'b0;
      do_reset();
      #2;
      vecs++;
      if (tmo !== 1'b0 || dut.state_q !== 2'd0 || pcw !== 1'b1 || pstall !== 1'b0) begin
         errs++; $display("FAIL halt_reset got tmo=%b state=%0d pcw=%b pstall=%b want 0 0 1 0", tmo, dut.state_q, pcw, pstall);
      end
      tick();
   endtask

   task automatic test_reset_mid_wait();
      req = 1'b1; rdy = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      #2;
      vecs++;
      if ({noop, pcw, pstall} !== 3'b100) begin
         errs++; $display("FAIL mid_wait_reset_ctl got %b want 100", {noop, pcw, pstall});
      end
      tick();
      vecs++;
      if (scnt !== 32'd0 || fcnt !== 32'd0) begin
         errs++; $display("FAIL mid_wait_reset_cnt got s=%0d f=%0d want 0 0", scnt, fcnt);
      end
      rst = 1'b0; req = 1'b0;
      #2;
      vecs++;
      if (dut.state_q !== 2'd0 || pcw !== 1'b1) begin
         errs++; $display("FAIL mid_wait_release got state=%0d pcw=%b want 0 1", dut.state_q, pcw);
      end
      tick();
   endtask

   task automatic test_saturation();
      logic [31:0] exp_s [4];
      exp_s[0] = 32'hFFFF_FFFE;
      exp_s[1] = 32'hFFFF_FFFF;
      exp_s[2] = 32'hFFFF_FFFF;
      exp_s[3] = 32'hFFFF_FFFF;
      do_reset();
      force dut.stall_cnt_q = 32'hFFFF_FFFD;
      #1;
      release dut.stall_cnt_q;
      req = 1'b1; rdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         vecs++;
         if (scnt !== exp_s[i]) begin
            errs++; $display("FAIL stall_sat_%0d got %h want %h", i, scnt, exp_s[i]);
         end
      end
      rdy = 1'b1;
      tick();
      idle_inputs();
      tick();
      vecs++;
      if (scnt !== 32'hFFFF_FFFF) begin
         errs++; $display("FAIL stall_sat_hold got %h want ffffffff", scnt);
      end
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_load_use();
      test_branch();
      test_mem_wait();
      test_watchdog();
      test_reset_mid_wait();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout bench did not finish");
      $fatal(1);
   end

endmodule
